// File: rtl/dbgapb_resp.sv
// dbgapb_resp: APB debug-port responder that launches committed debug commands to the core
module dbgapb_resp #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        dbg_psel,
    input  logic        dbg_penable,
    input  logic [31:0] dbg_paddr,
    input  logic        dbg_pwrite,
    input  logic [3:0]  dbg_pstrb,
    input  logic [31:0] dbg_pwdata,
    output logic [31:0] dbg_prdata,
    output logic        dbg_pslverr,
    output logic        dbg_pready,
    output logic [31:0] dbg_inst,
    output logic [31:0] dbg_wdata,
    output logic        dbg_inst_vld,
    input  logic        dbg_inst_rdy,
    input  logic        dbg_done,
    input  logic [31:0] dbg_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t           state_q;
    logic [31:0]      inst_sh_q, wdata_sh_q, inst_q, wdata_q, rdata_q;
    logic             err_q, done_q, vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx;
    logic             access, hit, busy, stall, wr, commit, fin, limit;
    logic [31:0]      mask, rd_mux;
    logic             unused_addr;
    assign unused_addr  = ^dbg_paddr[1:0];
    assign idx          = dbg_paddr[4:2];
    assign access       = dbg_psel & dbg_penable;
    assign hit          = (dbg_paddr[31:5] == '0) && (idx < 3'd6);
    assign busy         = state_q != IDLE;
    // only a result read or a new trigger has to wait for the in-flight command
    assign stall        = busy & hit & (dbg_pwrite ? idx == 3'd1 : idx == 3'd4);
    assign dbg_pready   = access & ~stall;
    assign dbg_pslverr  = dbg_pready & ~hit;
    assign wr           = dbg_pready & dbg_pwrite & hit;
    assign commit       = wr & (idx == 3'd1);
    assign mask         = {{8{dbg_pstrb[3]}}, {8{dbg_pstrb[2]}}, {8{dbg_pstrb[1]}}, {8{dbg_pstrb[0]}}};
    assign fin          = (state_q == WAIT) ? dbg_done : (state_q == ISSUE) & dbg_inst_rdy & dbg_done;
    assign limit        = cnt_q == CNT_W'(TIMEOUT - 1);
    assign dbg_prdata   = (dbg_pready & ~dbg_pwrite & hit) ? rd_mux : '0;
    assign dbg_inst     = inst_q;
    assign dbg_wdata    = wdata_q;
    assign dbg_inst_vld = vld_q;
    // read mux; trigger registers read as zero
    always_comb begin
        rd_mux = '0;
        case (idx)
            3'd0:    rd_mux = inst_sh_q;
            3'd2:    rd_mux = wdata_sh_q;
            3'd4:    rd_mux = rdata_q;
            3'd5:    rd_mux = {29'b0, err_q, busy, done_q};
            default: rd_mux = '0;
        endcase
    end
    // byte-masked shadow writes and WDATA commit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_sh_q  <= '0;
            wdata_sh_q <= '0;
            wdata_q    <= '0;
        end else if (wr) begin
            if (idx == 3'd0) inst_sh_q <= (inst_sh_q & ~mask) | (dbg_pwdata & mask);
            if (idx == 3'd2) wdata_sh_q <= (wdata_sh_q & ~mask) | (dbg_pwdata & mask);
            if (idx == 3'd3) wdata_q <= wdata_sh_q;
        end
    end
    // command FSM: completion beats timeout, timeout counts through ISSUE and WAIT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            inst_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (commit) begin
                state_q <= ISSUE;
                vld_q   <= 1'b1;
                inst_q  <= inst_sh_q;
                err_q   <= 1'b0;
                done_q  <= 1'b0;
                cnt_q   <= '0;
            end
        end else if (fin) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            rdata_q <= dbg_result;
            done_q  <= 1'b1;
        end else if (limit) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            err_q   <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == ISSUE && dbg_inst_rdy) begin
                state_q <= WAIT;
                vld_q   <= 1'b0;
            end
        end
    end
endmodule
